mcu_control: RTL and testbench
==============================

MCU_CONTROL -- requirements
Module: mcu_control

Interface
REQ-001 The block SHALL have parameter ALUC_W, default 2, giving the ALUControl width; legal values are 2 and 3.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have inputs Cond[3:0], Op[1:0], Funct[5:0], Rd[3:0] (instruction fields from the instruction register) and ALUFlags[3:0] (N,Z,C,V from the ALU).
REQ-005 The block SHALL have 1-bit outputs PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite and ALUSrcA.
REQ-006 The block SHALL have outputs ResultSrc[1:0], ALUSrcB[1:0], ImmSrc[1:0], RegSrc[1:0], ALUControl[ALUC_W-1:0] and State[3:0] (debug view of the current state).

Function
REQ-007 The FSM SHALL have these states and outputs:
- S0 Fetch=0: AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, IRWrite=1, NextPC=1.
- S1 Decode=1: ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
- S2 MemAdr=2: ALUSrcA=0, ALUSrcB=01.
- S3 MemRead=3: ResultSrc=00, AdrSrc=1.
- S4 MemWB=4: ResultSrc=01, RegW=1.
- S5 MemWr=5: ResultSrc=00, AdrSrc=1, MemW=1.
- S6 ExecR=6: ALUSrcA=0, ALUSrcB=00, ALUOp=1.
- S7 ExecI=7: ALUSrcA=0, ALUSrcB=01, ALUOp=1.
- S8 ALUWB=8: ResultSrc=00, RegW=1.
- S9 Branch=9: ALUSrcA=0, ALUSrcB=01, ResultSrc=10, Branch=1.
- Any output not listed for a state SHALL be 0.
REQ-008 Transitions SHALL be:
- Fetch->Decode.
- Decode: Op=01->MemAdr; Op=00 with Funct[5]=0->ExecR; Op=00 with Funct[5]=1->ExecI; Op=10->Branch; Op=11->Fetch.
- MemAdr: Funct[0]=1->MemRead, else MemWr.
- MemRead->MemWB; ExecR/ExecI->ALUWB.
- MemWB, MemWr, ALUWB, Branch->Fetch.
- State values 10-15->Fetch.
REQ-009 Decode SHALL be combinational from the current state and fields: ImmSrc=Op; RegSrc[0]=(Op==10); RegSrc[1]=(Op==01).
REQ-010 With ALUOp=0, ALUControl SHALL be ADD. With ALUOp=1, cmd=Funct[4:1] SHALL map ADD(0100)->0, SUB(0010)->1, AND(0000)->2, ORR(1100)->3.
REQ-011 With ALUC_W=3, the values of REQ-010 SHALL be zero-extended, and EOR(0001) SHALL map to 4. With ALUC_W=2, EOR is unsupported.
REQ-012 An unsupported cmd SHALL give ALUControl=ADD, FlagW=00 and suppress RegW in the following ALUWB.
REQ-013 FlagW SHALL be 00 unless ALUOp=1 and Funct[0]=1. In that case FlagW[1] (N,Z) SHALL be 1, and FlagW[0] (C,V) SHALL be 1 only for ADD/SUB.
REQ-014 Flag registers SHALL load ALUFlags on the clock edge when FlagW and CondEx are both set: FlagW[1] loads N,Z and FlagW[0] loads C,V.
REQ-015 CondEx SHALL be evaluated combinationally from Cond and the stored flags, per the standard ARM table EQ..LE (0000-1101) and AL=1110. Cond=1111 SHALL give CondEx=0.
REQ-016 PCS SHALL equal Branch | (RegW & Rd==1111).
REQ-017 Gated outputs SHALL be:
- PCWrite = NextPC | (PCS & CondEx).
- RegWrite = RegW & CondEx.
- MemWrite = MemW & CondEx.
REQ-018 Instruction latency SHALL be: load 5, store 4, data-processing 4, branch 3 cycles.
REQ-019 Flags written in ExecR/ExecI SHALL be visible to CondEx from ALUWB onward, so ALUWB uses the flags as updated by the same instruction.

Reset
REQ-020 When rst_n=0, state SHALL go to Fetch and all four flags to 0 immediately, independent of clk.
REQ-021 While rst_n=0, PCWrite, IRWrite, RegWrite and MemWrite SHALL be forced to 0; all other outputs SHALL take their Fetch values.
REQ-022 Reset asserted mid-instruction SHALL abandon the instruction with no further write strobes; after release, the first rising edge leaves Fetch.

Configuration
REQ-023 When macro MCU_CMP_EN is defined, cmd 1010 (CMP) SHALL decode as ALUControl=SUB and FlagW=11 (regardless of Funct[0]), with RegW suppressed in ALUWB.
REQ-024 When MCU_CMP_EN is undefined, cmd 1010 SHALL be treated as unsupported per REQ-012.

Verification
REQ-025 Reset: hold rst_n=0 mid-ExecR -> State=0 immediately, flags=0000, all write strobes 0; after release, State sequence is 0,1.
REQ-026 LDR (Op=01, Funct[0]=1, Cond=1110) -> States 0,1,2,3,4; RegWrite=1 only in State 4; ResultSrc=01 in State 4.
REQ-027 Run in order:
- ADDS (cmd 0100, S=1) with ALUFlags=0100 -> Z stored.
- Then BEQ (Op=10, Cond=0000) -> PCWrite=1 in Branch.
- Then BNE -> PCWrite=0 in Branch.
REQ-028 Run in order:
- STR (Op=01, Funct[0]=0) with Cond=0001 and Z=1 -> MemWrite=0 in State 5.
- Same STR with Z=0 -> MemWrite=1.
REQ-029 Data-processing with Rd=1111, Cond=1110 -> PCWrite=1 and RegWrite=1 in ALUWB.
REQ-030 ALUC_W=3, EOR (cmd 0001) -> ALUControl=100. ALUC_W=2, EOR -> ALUControl=00 and RegWrite=0 in ALUWB. CMP with MCU_CMP_EN -> ALUControl=01, FlagW=11, RegWrite=0.

Source files
------------

// File: rtl/mcu_control.sv
// mcu_control: multicycle main controller for an ARM-subset datapath.
// A ten-state FSM sequences each instruction. A combinational decoder
// produces the ALU command and the flag-write enables. The flag registers
// drive a condition check that gates PC, register and memory writes.
// Optional feature: define MCU_CMP_EN to decode cmd 1010 (CMP) as SUB.
// CMP then writes all four flags and suppresses the register write.
module mcu_control #(
  parameter int ALUC_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        Cond,
  input  logic [1:0]        Op,
  input  logic [5:0]        Funct,
  input  logic [3:0]        Rd,
  input  logic [3:0]        ALUFlags,
  output logic              PCWrite,
  output logic              AdrSrc,
  output logic              MemWrite,
  output logic              IRWrite,
  output logic              RegWrite,
  output logic              ALUSrcA,
  output logic [1:0]        ResultSrc,
  output logic [1:0]        ALUSrcB,
  output logic [1:0]        ImmSrc,
  output logic [1:0]        RegSrc,
  output logic [ALUC_W-1:0] ALUControl,
  output logic [3:0]        State
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMREAD = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECR   = 4'd6,
    S_EXECI   = 4'd7,
    S_ALUWB   = 4'd8,
    S_BRANCH  = 4'd9
  } state_t;

  state_t state, state_nxt;

  logic              adr_src, alu_src_a, ir_write, next_pc;
  logic              reg_w, mem_w, branch, alu_op;
  logic [1:0]        result_src, alu_src_b;
  logic [3:0]        cmd;
  logic [ALUC_W-1:0] alu_ctl;
  logic [1:0]        flag_w;
  logic              dp_nowrite, nowrite_q;
  logic              flag_n, flag_z, flag_c, flag_v;
  logic              cond_ex, pcs;

  // State register: reset returns to Fetch at once, independent of clk
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= state_nxt;
  end

  // Next-state logic; unused encodings fall back to Fetch
  always_comb begin
    state_nxt = S_FETCH;
    case (state)
      S_FETCH:   state_nxt = S_DECODE;
      S_DECODE: begin
        case (Op)
          2'b01:   state_nxt = S_MEMADR;
          2'b00:   state_nxt = Funct[5] ? S_EXECI : S_EXECR;
          2'b10:   state_nxt = S_BRANCH;
          default: state_nxt = S_FETCH;
        endcase
      end
      S_MEMADR:  state_nxt = Funct[0] ? S_MEMREAD : S_MEMWR;
      S_MEMREAD: state_nxt = S_MEMWB;
      S_EXECR:   state_nxt = S_ALUWB;
      S_EXECI:   state_nxt = S_ALUWB;
      default:   state_nxt = S_FETCH;
    endcase
  end

  // Per-state control outputs; anything not set for a state stays 0
  always_comb begin
    adr_src    = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    result_src = 2'b00;
    ir_write   = 1'b0;
    next_pc    = 1'b0;
    reg_w      = 1'b0;
    mem_w      = 1'b0;
    branch     = 1'b0;
    alu_op     = 1'b0;
    case (state)
      S_FETCH: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = 1'b1;
        next_pc    = 1'b1;
      end
      S_DECODE: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
      end
      S_MEMADR:  alu_src_b = 2'b01;
      S_MEMREAD: adr_src = 1'b1;
      S_MEMWB: begin
        result_src = 2'b01;
        reg_w      = 1'b1;
      end
      S_MEMWR: begin
        adr_src = 1'b1;
        mem_w   = 1'b1;
      end
      S_EXECR:   alu_op = 1'b1;
      S_EXECI: begin
        alu_src_b = 2'b01;
        alu_op    = 1'b1;
      end
      S_ALUWB:   reg_w = ~nowrite_q;
      S_BRANCH: begin
        alu_src_b  = 2'b01;
        result_src = 2'b10;
        branch     = 1'b1;
      end
      default: ;
    endcase
  end

  // ALU decoder: command mapping, flag-write enables, unsupported-command detect
  always_comb begin
    cmd        = Funct[4:1];
    alu_ctl    = '0;
    flag_w     = 2'b00;
    dp_nowrite = 1'b0;
    if (alu_op) begin
      case (cmd)
        4'b0100: begin
          alu_ctl = ALUC_W'(0);
          flag_w  = {Funct[0], Funct[0]};
        end
        4'b0010: begin
          alu_ctl = ALUC_W'(1);
          flag_w  = {Funct[0], Funct[0]};
        end
        4'b0000: begin
          alu_ctl = ALUC_W'(2);
          flag_w  = {Funct[0], 1'b0};
        end
        4'b1100: begin
          alu_ctl = ALUC_W'(3);
          flag_w  = {Funct[0], 1'b0};
        end
        4'b0001: begin
          if (ALUC_W >= 3) begin
            alu_ctl = ALUC_W'(4);
            flag_w  = {Funct[0], 1'b0};
          end else begin
            dp_nowrite = 1'b1;
          end
        end
`ifdef MCU_CMP_EN
        4'b1010: begin
          alu_ctl    = ALUC_W'(1);
          flag_w     = 2'b11;
          dp_nowrite = 1'b1;
        end
`else
        4'b1010: dp_nowrite = 1'b1;
`endif
        default: dp_nowrite = 1'b1;
      endcase
    end
  end

  // Write-suppress decision taken in Exec; the ALUWB state that follows uses it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      nowrite_q <= 1'b0;
    else if (alu_op) nowrite_q <= dp_nowrite;
  end

  // Flag registers: conditional load of N,Z and C,V halves
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_n <= 1'b0;
      flag_z <= 1'b0;
      flag_c <= 1'b0;
      flag_v <= 1'b0;
    end else begin
      if (flag_w[1] && cond_ex) begin
        flag_n <= ALUFlags[3];
        flag_z <= ALUFlags[2];
      end
      if (flag_w[0] && cond_ex) begin
        flag_c <= ALUFlags[1];
        flag_v <= ALUFlags[0];
      end
    end
  end

  // Condition check against the stored flags; 1111 never executes
  always_comb begin
    cond_ex = 1'b0;
    case (Cond)
      4'b0000: cond_ex = flag_z;
      4'b0001: cond_ex = ~flag_z;
      4'b0010: cond_ex = flag_c;
      4'b0011: cond_ex = ~flag_c;
      4'b0100: cond_ex = flag_n;
      4'b0101: cond_ex = ~flag_n;
      4'b0110: cond_ex = flag_v;
      4'b0111: cond_ex = ~flag_v;
      4'b1000: cond_ex = flag_c & ~flag_z;
      4'b1001: cond_ex = ~flag_c | flag_z;
      4'b1010: cond_ex = (flag_n == flag_v);
      4'b1011: cond_ex = (flag_n != flag_v);
      4'b1100: cond_ex = ~flag_z & (flag_n == flag_v);
      4'b1101: cond_ex = flag_z | (flag_n != flag_v);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  assign pcs = branch | (reg_w & (Rd == 4'hF));

  // Write strobes are held low while reset is asserted
  assign PCWrite    = rst_n & (next_pc | (pcs & cond_ex));
  assign RegWrite   = rst_n & reg_w & cond_ex;
  assign MemWrite   = rst_n & mem_w & cond_ex;
  assign IRWrite    = rst_n & ir_write;
  assign AdrSrc     = adr_src;
  assign ALUSrcA    = alu_src_a;
  assign ALUSrcB    = alu_src_b;
  assign ResultSrc  = result_src;
  assign ImmSrc     = Op;
  assign RegSrc     = {Op == 2'b01, Op == 2'b10};
  assign ALUControl = alu_ctl;
  assign State      = state;

endmodule

// File: tb/tb_mcu_control.sv
// tb_mcu_control: directed and randomized checks of mcu_control.
// Two instances (ALUC_W=2 and ALUC_W=3) share the same stimulus.
// Each instance is compared every cycle against an instruction-level reference model.
module tb_mcu_control;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] Cond = '0;
  logic [1:0] Op = '0;
  logic [5:0] Funct = '0;
  logic [3:0] Rd = '0;
  logic [3:0] ALUFlags = '0;

  logic       PCWrite2, AdrSrc2, MemWrite2, IRWrite2, RegWrite2, ALUSrcA2;
  logic [1:0] ResultSrc2, ALUSrcB2, ImmSrc2, RegSrc2, ALUControl2;
  logic [3:0] State2;
  logic       PCWrite3, AdrSrc3, MemWrite3, IRWrite3, RegWrite3, ALUSrcA3;
  logic [1:0] ResultSrc3, ALUSrcB3, ImmSrc3, RegSrc3;
  logic [2:0] ALUControl3;
  logic [3:0] State3;

  mcu_control #(.ALUC_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd),
    .ALUFlags(ALUFlags), .PCWrite(PCWrite2), .AdrSrc(AdrSrc2), .MemWrite(MemWrite2),
    .IRWrite(IRWrite2), .RegWrite(RegWrite2), .ALUSrcA(ALUSrcA2),
    .ResultSrc(ResultSrc2), .ALUSrcB(ALUSrcB2), .ImmSrc(ImmSrc2), .RegSrc(RegSrc2),
    .ALUControl(ALUControl2), .State(State2)
  );

  mcu_control #(.ALUC_W(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd),
    .ALUFlags(ALUFlags), .PCWrite(PCWrite3), .AdrSrc(AdrSrc3), .MemWrite(MemWrite3),
    .IRWrite(IRWrite3), .RegWrite(RegWrite3), .ALUSrcA(ALUSrcA3),
    .ResultSrc(ResultSrc3), .ALUSrcB(ALUSrcB3), .ImmSrc(ImmSrc3), .RegSrc(RegSrc3),
    .ALUControl(ALUControl3), .State(State3)
  );

  always #5 clk = ~clk;

  // Observed output vectors: {PCWrite,AdrSrc,MemWrite,IRWrite,RegWrite,ALUSrcA,
  // ResultSrc,ALUSrcB,ImmSrc,RegSrc,ALUControl(3b),State}
  logic [20:0] obs2, obs3;
  assign obs2 = {PCWrite2, AdrSrc2, MemWrite2, IRWrite2, RegWrite2, ALUSrcA2,
                 ResultSrc2, ALUSrcB2, ImmSrc2, RegSrc2, 1'b0, ALUControl2, State2};
  assign obs3 = {PCWrite3, AdrSrc3, MemWrite3, IRWrite3, RegWrite3, ALUSrcA3,
                 ResultSrc3, ALUSrcB3, ImmSrc3, RegSrc3, ALUControl3, State3};

  typedef struct packed {
    logic       ok;
    logic [2:0] aluc;
    logic [1:0] flagw;
    logic       nowrite;
  } dp_t;

  int checks = 0;
  int passed = 0;
  int fails  = 0;
  logic [3:0] mflags [2];   // model flags {N,Z,C,V}: [0] for ALUC_W=2, [1] for ALUC_W=3

  function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] fl);
    logic n, z, cy, v;
    {n, z, cy, v} = fl;
    case (c)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return cy;
      4'h3: return !cy;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return cy && !z;
      4'h9: return !cy || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic dp_t dp_decode(input int w, input logic [5:0] f);
    dp_t  d;
    logic arith, cmp;
    d = '0;
    d.ok = 1'b1;
    arith = 1'b0;
    cmp = 1'b0;
    case (f[4:1])
      4'b0100: begin d.aluc = 3'd0; arith = 1'b1; end
      4'b0010: begin d.aluc = 3'd1; arith = 1'b1; end
      4'b0000: d.aluc = 3'd2;
      4'b1100: d.aluc = 3'd3;
      4'b0001: if (w == 3) d.aluc = 3'd4; else d.ok = 1'b0;
      4'b1010: begin
`ifdef MCU_CMP_EN
        cmp = 1'b1;
`else
        d.ok = 1'b0;
`endif
      end
      default: d.ok = 1'b0;
    endcase
    if (cmp) begin
      d.aluc = 3'd1; d.flagw = 2'b11; d.nowrite = 1'b1;
    end else if (!d.ok) begin
      d.aluc = 3'd0; d.flagw = 2'b00; d.nowrite = 1'b1;
    end else begin
      d.flagw = f[0] ? {1'b1, arith} : 2'b00;
    end
    return d;
  endfunction

  function automatic logic [20:0] exp_vec(input logic [3:0] st, input logic [1:0] op,
                                          input logic [3:0] c, input logic [3:0] rd,
                                          input logic [3:0] fl, input dp_t d);
    logic adr, srca, irw, npc, regw, memw, br, aluop, ce, pcs;
    logic [1:0] rs, sb;
    logic [2:0] aluc;
    {adr, srca, irw, npc, regw, memw, br, aluop} = '0;
    rs = 2'b00;
    sb = 2'b00;
    case (st)
      4'd0: begin srca = 1; sb = 2'b10; rs = 2'b10; irw = 1; npc = 1; end
      4'd1: begin srca = 1; sb = 2'b10; rs = 2'b10; end
      4'd2: sb = 2'b01;
      4'd3: adr = 1;
      4'd4: begin rs = 2'b01; regw = 1; end
      4'd5: begin adr = 1; memw = 1; end
      4'd6: aluop = 1;
      4'd7: begin sb = 2'b01; aluop = 1; end
      4'd8: regw = !d.nowrite;
      4'd9: begin sb = 2'b01; rs = 2'b10; br = 1; end
      default: ;
    endcase
    ce   = cond_ok(c, fl);
    pcs  = br || (regw && rd == 4'hF);
    aluc = aluop ? d.aluc : 3'd0;
    return {npc | (pcs & ce), adr, memw & ce, irw, regw & ce, srca, rs, sb, op,
            op == 2'b01, op == 2'b10, aluc, st};
  endfunction

  function automatic logic [20:0] exp_reset(input logic [1:0] op);
    return {5'b00000, 1'b1, 2'b10, 2'b10, op, op == 2'b01, op == 2'b10, 3'b000, 4'h0};
  endfunction

  task automatic check(input string tag, input logic [20:0] obs, input logic [20:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "/w2"}, obs2, exp_reset(Op));
    check({tag, "/w3"}, obs3, exp_reset(Op));
  endtask

  // Runs one instruction starting at a negedge with both DUTs in Fetch;
  // returns at the negedge where they are back in Fetch.
  task automatic run_instr(input string tag, input logic [1:0] op, input logic [5:0] funct,
                           input logic [3:0] cond, input logic [3:0] rd,
                           input logic [3:0] alu_flags);
    int  seq[$];
    dp_t d [2];
    Op = op; Funct = funct; Cond = cond; Rd = rd; ALUFlags = alu_flags;
    d[0] = dp_decode(2, funct);
    d[1] = dp_decode(3, funct);
    seq.push_back(0);
    seq.push_back(1);
    case (op)
      2'b00: begin seq.push_back(funct[5] ? 7 : 6); seq.push_back(8); end
      2'b01: begin
        seq.push_back(2);
        if (funct[0]) begin seq.push_back(3); seq.push_back(4); end
        else seq.push_back(5);
      end
      2'b10: seq.push_back(9);
      default: ;
    endcase
    foreach (seq[i]) begin
      #1;
      for (int k = 0; k < 2; k++)
        check($sformatf("%s/w%0d/s%0d", tag, k + 2, seq[i]), (k == 0) ? obs2 : obs3,
              exp_vec(4'(seq[i]), op, cond, rd, mflags[k], d[k]));
      if (seq[i] == 6 || seq[i] == 7) begin
        for (int k = 0; k < 2; k++) begin
          if (cond_ok(cond, mflags[k])) begin
            if (d[k].flagw[1]) mflags[k][3:2] = alu_flags[3:2];
            if (d[k].flagw[0]) mflags[k][1:0] = alu_flags[1:0];
          end
        end
      end
      @(negedge clk);
    end
  endtask

  initial begin
    mflags[0] = 4'h0;
    mflags[1] = 4'h0;

    // Reset held from time 0, across a rising edge
    #3 check_reset("rst_init");
    @(negedge clk);
    #1 check_reset("rst_hold");
    @(negedge clk);
    rst_n = 1'b1;

    // LDR, STR with condition on Z, flag-setting ADDS then BEQ/BNE
    run_instr("ldr",      2'b01, 6'b011001, 4'hE, 4'h3, 4'h0);
    run_instr("adds_z",   2'b00, 6'b001001, 4'hE, 4'h1, 4'b0100);
    run_instr("beq",      2'b10, 6'b000000, 4'h0, 4'h0, 4'h0);
    run_instr("bne",      2'b10, 6'b000000, 4'h1, 4'h0, 4'h0);
    run_instr("str_ne_z1", 2'b01, 6'b011000, 4'h1, 4'h4, 4'h0);
    run_instr("adds_clr", 2'b00, 6'b001001, 4'hE, 4'h1, 4'b0000);
    run_instr("str_ne_z0", 2'b01, 6'b011000, 4'h1, 4'h4, 4'h0);
    run_instr("add_pc",   2'b00, 6'b001000, 4'hE, 4'hF, 4'h0);
    run_instr("ldr_pc",   2'b01, 6'b000001, 4'hE, 4'hF, 4'h0);
    run_instr("eor_s",    2'b00, 6'b000011, 4'hE, 4'h5, 4'b1011);
    run_instr("cmp",      2'b00, 6'b110101, 4'hE, 4'h6, 4'b0011);
    run_instr("cmp_ns",   2'b00, 6'b010100, 4'hE, 4'h6, 4'b1111);
    run_instr("unsup_s",  2'b00, 6'b001111, 4'hE, 4'hF, 4'b1111);
    run_instr("subs_i",   2'b00, 6'b100101, 4'hE, 4'h2, 4'b1001);
    run_instr("op11",     2'b11, 6'b000000, 4'hE, 4'h0, 4'h0);
    run_instr("nv_cond",  2'b00, 6'b001000, 4'hF, 4'hF, 4'h0);
    run_instr("adds_z2",  2'b00, 6'b001001, 4'hE, 4'h1, 4'b0100);

    // Reset asserted in ExecR: instruction abandoned, flags cleared
    Op = 2'b00; Funct = 6'b001001; Cond = 4'hE; Rd = 4'hF; ALUFlags = 4'b1111;
    @(negedge clk);
    @(negedge clk);
    #1 check("pre_rst_execr/w2", obs2, exp_vec(4'd6, Op, Cond, Rd, mflags[0], dp_decode(2, Funct)));
    #2 rst_n = 1'b0;
    mflags[0] = 4'h0;
    mflags[1] = 4'h0;
    #1 check_reset("rst_mid");
    @(negedge clk);
    #1 check_reset("rst_mid_hold");
    @(negedge clk);
    rst_n = 1'b1;
    run_instr("beq_after_rst", 2'b10, 6'b000000, 4'h0, 4'h0, 4'h0);
    run_instr("bne_after_rst", 2'b10, 6'b000000, 4'h1, 4'h0, 4'h0);

    // Randomized instruction stream
    for (int i = 0; i < 80; i++) begin
      logic [1:0] op;
      logic [5:0] fn;
      op = 2'($urandom_range(0, 3));
      fn = 6'($urandom);
      if ($urandom_range(0, 3) == 0) fn[4:1] = 4'b0001;
      run_instr($sformatf("rnd%0d", i), op, fn, 4'($urandom), 4'($urandom), 4'($urandom));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
